// File: rtl/conv_loader.sv
// rtl/conv_loader.sv - byte-stream loader for the conv image and weight arrays, with trigger/wait handshake.
// Optional CONV_LOADER_WEIGHT_KEEP_EN: after the first full frame, later frames carry the image only.
module conv_loader #(
    parameter int K_H  = 3,
    parameter int K_W  = 3,
    parameter int IN_H = 16,
    parameter int IN_W = 15,
    parameter int CHAN = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [7:0]        in_img  [IN_H][IN_W],
    output logic signed [7:0] w_conv1 [K_H][K_W][CHAN],
    output logic signed [7:0] w_conv2 [K_H][K_W][CHAN],
    output logic              trigger,
    input  logic              conv_out_valid,
    input  logic [3:0]        conv_out_chan,
    output logic              busy,
    output logic              frame_done
);
    localparam int RW  = (IN_H > 1) ? $clog2(IN_H) : 1;
    localparam int CW  = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int KHW = (K_H > 1) ? $clog2(K_H) : 1;
    localparam int KWW = (K_W > 1) ? $clog2(K_W) : 1;
    localparam int CHW = (CHAN > 1) ? $clog2(CHAN) : 1;

    localparam logic [2:0] ST_IMG  = 3'd0;
    localparam logic [2:0] ST_W1   = 3'd1;
    localparam logic [2:0] ST_W2   = 3'd2;
    localparam logic [2:0] ST_FIRE = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;

    logic [2:0]     state;
    logic [RW-1:0]  row;
    logic [CW-1:0]  col;
    logic [KHW-1:0] kh;
    logic [KWW-1:0] kw;
    logic [CHW-1:0] ch;
`ifdef CONV_LOADER_WEIGHT_KEEP_EN
    logic           weights_loaded;
`endif

    logic img_last;
    logic w_last;
    logic last_chan_seen;

    assign s_ready  = (state == ST_IMG) || (state == ST_W1) || (state == ST_W2);
    assign trigger  = (state == ST_FIRE);
    assign busy     = (state == ST_FIRE) || (state == ST_WAIT);
    assign img_last = (row == RW'(IN_H - 1)) && (col == CW'(IN_W - 1));
    assign w_last   = (kh == KHW'(K_H - 1)) && (kw == KWW'(K_W - 1)) && (ch == CHW'(CHAN - 1));
    assign last_chan_seen = conv_out_valid && (conv_out_chan == 4'(CHAN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IMG;
            row        <= '0;
            col        <= '0;
            kh         <= '0;
            kw         <= '0;
            ch         <= '0;
            frame_done <= 1'b0;
`ifdef CONV_LOADER_WEIGHT_KEEP_EN
            weights_loaded <= 1'b0;
`endif
            for (int i = 0; i < IN_H; i++)
                for (int j = 0; j < IN_W; j++)
                    in_img[i][j] <= '0;
            for (int i = 0; i < K_H; i++)
                for (int j = 0; j < K_W; j++)
                    for (int k = 0; k < CHAN; k++) begin
                        w_conv1[i][j][k] <= '0;
                        w_conv2[i][j][k] <= '0;
                    end
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IMG: begin
                    if (s_valid) begin
                        in_img[row][col] <= s_data;
                        if (col == CW'(IN_W - 1)) begin
                            col <= '0;
                            row <= (row == RW'(IN_H - 1)) ? '0 : row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (img_last) begin
`ifdef CONV_LOADER_WEIGHT_KEEP_EN
                            state <= weights_loaded ? ST_FIRE : ST_W1;
`else
                            state <= ST_W1;
`endif
                        end
                    end
                end
                ST_W1, ST_W2: begin
                    if (s_valid) begin
                        if (state == ST_W1)
                            w_conv1[kh][kw][ch] <= $signed(s_data);
                        else
                            w_conv2[kh][kw][ch] <= $signed(s_data);
                        // channel fastest, then kw, then kh
                        if (ch == CHW'(CHAN - 1)) begin
                            ch <= '0;
                            if (kw == KWW'(K_W - 1)) begin
                                kw <= '0;
                                kh <= (kh == KHW'(K_H - 1)) ? '0 : kh + 1'b1;
                            end else begin
                                kw <= kw + 1'b1;
                            end
                        end else begin
                            ch <= ch + 1'b1;
                        end
                        if (w_last) begin
                            state <= (state == ST_W1) ? ST_W2 : ST_FIRE;
`ifdef CONV_LOADER_WEIGHT_KEEP_EN
                            if (state == ST_W2)
                                weights_loaded <= 1'b1;
`endif
                        end
                    end
                end
                ST_FIRE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (last_chan_seen) begin
                        frame_done <= 1'b1;
                        state      <= ST_IMG;
                        row        <= '0;
                        col        <= '0;
                        kh         <= '0;
                        kw         <= '0;
                        ch         <= '0;
                    end
                end
                default: state <= ST_IMG;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_loader.sv
// tb/tb_conv_loader.sv - self-checking bench for conv_loader against a flat byte-index model.
module tb_conv_loader;
    localparam int K_H   = 3;
    localparam int K_W   = 3;
    localparam int IN_H  = 16;
    localparam int IN_W  = 15;
    localparam int CHAN  = 10;
    localparam int N_IMG = IN_H * IN_W;
    localparam int N_W   = K_H * K_W * CHAN;
`ifdef CONV_LOADER_WEIGHT_KEEP_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        s_data = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [7:0]        in_img  [IN_H][IN_W];
    logic signed [7:0] w_conv1 [K_H][K_W][CHAN];
    logic signed [7:0] w_conv2 [K_H][K_W][CHAN];
    logic              trigger;
    logic              conv_out_valid = 1'b0;
    logic [3:0]        conv_out_chan = '0;
    logic              busy;
    logic              frame_done;

    int n_vec = 0;
    int n_err = 0;
    int trig_cnt = 0;

    // Model: byte position within a frame decides the destination element.
    logic [7:0] m_img [N_IMG];
    logic [7:0] m_w1  [N_W];
    logic [7:0] m_w2  [N_W];
    int         m_cnt;
    int         m_phase;   // 0 loading, 1 fire cycle, 2 waiting on conv
    bit         m_done;
    bit         m_wkeep;

    conv_loader #(.K_H(K_H), .K_W(K_W), .IN_H(IN_H), .IN_W(IN_W), .CHAN(CHAN)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .in_img(in_img), .w_conv1(w_conv1), .w_conv2(w_conv2), .trigger(trigger),
        .conv_out_valid(conv_out_valid), .conv_out_chan(conv_out_chan),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic int frame_len();
        return (KEEP && m_wkeep) ? N_IMG : N_IMG + 2 * N_W;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   <= 0;
            m_phase <= 0;
            m_done  <= 1'b0;
            m_wkeep <= 1'b0;
            for (int i = 0; i < N_IMG; i++) m_img[i] <= '0;
            for (int i = 0; i < N_W; i++) begin
                m_w1[i] <= '0;
                m_w2[i] <= '0;
            end
        end else begin
            m_done <= 1'b0;
            if (m_phase == 0 && s_valid) begin
                if (m_cnt < N_IMG) m_img[m_cnt] <= s_data;
                else if (m_cnt < N_IMG + N_W) m_w1[m_cnt - N_IMG] <= s_data;
                else m_w2[m_cnt - N_IMG - N_W] <= s_data;
                if (m_cnt == frame_len() - 1) begin
                    m_cnt   <= 0;
                    m_phase <= 1;
                    if (frame_len() == N_IMG + 2 * N_W) m_wkeep <= 1'b1;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end else if (m_phase == 1) begin
                m_phase <= 2;
            end else if (m_phase == 2 && conv_out_valid && conv_out_chan == 4'(CHAN - 1)) begin
                m_phase <= 0;
                m_done  <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("s_ready", 32'(s_ready), 32'(m_phase == 0));
            chk("trigger", 32'(trigger), 32'(m_phase == 1));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("frame_done", 32'(frame_done), 32'(m_done));
        end
    end

    always @(negedge clk) if (trigger) trig_cnt <= trig_cnt + 1;

    task automatic check_arrays(input string tag);
        int bad_img, bad_w1, bad_w2;
        logic [7:0] act, exp;
        bad_img = 0; bad_w1 = 0; bad_w2 = 0;
        act = '0; exp = '0;
        for (int r = 0; r < IN_H; r++)
            for (int c = 0; c < IN_W; c++)
                if (in_img[r][c] !== m_img[r * IN_W + c]) begin
                    if (bad_img == 0) begin act = in_img[r][c]; exp = m_img[r * IN_W + c]; end
                    bad_img++;
                end
        chk({tag, "_in_img"}, 32'(act), 32'(exp));
        act = '0; exp = '0;
        for (int a = 0; a < K_H; a++)
            for (int b = 0; b < K_W; b++)
                for (int k = 0; k < CHAN; k++)
                    if ($unsigned(w_conv1[a][b][k]) !== m_w1[a * K_W * CHAN + b * CHAN + k]) begin
                        if (bad_w1 == 0) begin act = w_conv1[a][b][k]; exp = m_w1[a * K_W * CHAN + b * CHAN + k]; end
                        bad_w1++;
                    end
        chk({tag, "_w_conv1"}, 32'(act), 32'(exp));
        act = '0; exp = '0;
        for (int a = 0; a < K_H; a++)
            for (int b = 0; b < K_W; b++)
                for (int k = 0; k < CHAN; k++)
                    if ($unsigned(w_conv2[a][b][k]) !== m_w2[a * K_W * CHAN + b * CHAN + k]) begin
                        if (bad_w2 == 0) begin act = w_conv2[a][b][k]; exp = m_w2[a * K_W * CHAN + b * CHAN + k]; end
                        bad_w2++;
                    end
        chk({tag, "_w_conv2"}, 32'(act), 32'(exp));
    endtask

    task automatic send_byte(input logic [7:0] v);
        int guard;
        guard = 0;
        s_data  = v;
        s_valid = 1'b1;
        while (!s_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("send_timeout", 32'(guard >= 50), 32'd0);
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input int n, input int mul, input int add, input bit tog);
        for (int i = 0; i < n; i++) begin
            send_byte(8'((i * mul + add) % 256));
            if (tog && i != n - 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic finish_frame(input bit hold);
        for (int c = 0; c < CHAN - 1; c++) begin
            s_valid = hold;
            s_data = 8'hAA;
            conv_out_valid = 1'b1;
            conv_out_chan = 4'(c);
            @(posedge clk); #1;
            chk("no_early_done", 32'(frame_done), 32'd0);
        end
        s_valid = 1'b0;
        conv_out_chan = 4'(CHAN - 1);
        @(posedge clk); #1;
        conv_out_valid = 1'b0;
        chk("done_pulse", 32'(frame_done), 32'd1);
        chk("busy_fall", 32'(busy), 32'd0);
        chk("ready_back", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(frame_done), 32'd0);
    endtask

    initial begin
        int t0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_arrays("reset");
        chk("reset_s_ready", 32'(s_ready), 32'd1);
        chk("reset_trigger", 32'(trigger), 32'd0);
        rst = 1'b0;

        // Frame 1: value = index mod 256, continuous valid
        t0 = trig_cnt;
        send_frame(frame_len(), 1, 0, 1'b0);
        chk("trig_after_last", 32'(trigger), 32'd1);
        chk("img_0_0", 32'(in_img[0][0]), 32'd0);
        chk("img_15_14", 32'(in_img[15][14]), 32'd239);
        chk("w1_0_0_0", 32'($unsigned(w_conv1[0][0][0])), 32'd240);
        chk("w2_2_2_9", 32'($unsigned(w_conv2[2][2][9])), 32'd163);
        check_arrays("frame1");
        // valid held through FIRE/WAIT must not disturb the arrays
        s_valid = 1'b1;
        s_data = 8'h55;
        repeat (4) begin @(posedge clk); #1; end
        check_arrays("frozen");
        finish_frame(1'b1);
        chk("one_trigger", 32'(trig_cnt - t0), 32'd1);
        check_arrays("after_done");

        // Frame 2: toggled valid
        t0 = trig_cnt;
        send_frame(frame_len(), 1, 0, 1'b1);
        chk("trig_after_last_tog", 32'(trigger), 32'd1);
        check_arrays("frame2");
        finish_frame(1'b0);
        chk("one_trigger_tog", 32'(trig_cnt - t0), 32'd1);

        // Last-channel report while loading is ignored
        conv_out_valid = 1'b1;
        conv_out_chan = 4'(CHAN - 1);
        repeat (2) begin @(posedge clk); #1; end
        conv_out_valid = 1'b0;
        chk("idle_no_done", 32'(frame_done), 32'd0);

        // Reset after 100 bytes discards the partial frame
        send_frame(100, 7, 3, 1'b0);
        rst = 1'b1;
        #1;
        check_arrays("midrst");
        chk("midrst_img", 32'(in_img[0][0]), 32'd0);
        chk("midrst_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame 3: value = (3*i+1) mod 256
        t0 = trig_cnt;
        send_frame(frame_len(), 3, 1, 1'b0);
        chk("trig_after_last_f3", 32'(trigger), 32'd1);
        chk("w1_f3", 32'($unsigned(w_conv1[0][0][0])), 32'd209);
        check_arrays("frame3");
        finish_frame(1'b0);
        chk("one_trigger_f3", 32'(trig_cnt - t0), 32'd1);

        // Frame 4: image-only when weights are kept
        send_frame(frame_len(), 5, 2, 1'b0);
        chk("trig_after_last_f4", 32'(trigger), 32'd1);
`ifdef CONV_LOADER_WEIGHT_KEEP_EN
        chk("keep_w1", 32'($unsigned(w_conv1[0][0][0])), 32'd209);
        chk("keep_img", 32'(in_img[0][1]), 32'd7);
`endif
        check_arrays("frame4");
        finish_frame(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
